ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC register and issues requests to instruction memory, which may insert wait states.
- Holds the fetched word stable for decode until the decode/execute side consumes it.
- On consumption, resolves beq/bne using the decoder's branch output and the ALU zero flag, then redirects to PC+imm or PC+4.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MAX_WAIT, 15, maximum imem wait cycles per request before a fetch error is flagged (1..255).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- imem_req, output, 1, fetch request; high only in state FETCH.
- imem_addr, output, 32, word address of the fetch; equals pc.
- imem_rdata, input, 32, instruction word; valid when imem_ready=1.
- imem_ready, input, 1, memory has data this cycle; ignored when imem_req=0.
- stall, input, 1, downstream not ready; holds the current instruction.
- branch, input, 1, branch control from the main decoder.
- fun3, input, 3, funct3 of the held instruction.
- zeroflag, input, 1, ALU zero result for the held instruction.
- imm_ext, input, 32, sign-extended branch immediate.
- instr, output, 32, held instruction to decode.
- instr_pc, output, 32, address of instr.
- instr_valid, output, 1, instr is valid for decode/execute.
- fetch_err, output, 1, sticky error (timeout or misaligned target).

Behaviour:
- States: FETCH, HOLD, ERR.
- Reset (async, immediate):
  - state=FETCH, pc=RESET_PC, wait_cnt=0.
  - instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, fetch_err=0.
  - imem_req is held low while rst=1 and goes high from the first cycle after rst deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ready=1 at the clock edge: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, wait_cnt<=0, go HOLD.
  - Otherwise wait_cnt<=wait_cnt+1. When wait_cnt==MAX_WAIT with no ready, go ERR and set fetch_err<=1.
  - A ready on the request cycle gives a 1-cycle fetch latency, so instr_valid rises one edge after the ready cycle.
- HOLD:
  - imem_req=0; instr, instr_pc and instr_valid stay stable while stall=1, with no limit on hold duration.
  - On an edge with stall=0 the instruction retires: instr_valid<=0 and pc<=next_pc, then go FETCH.
  - Retirement uses branch, fun3, zeroflag and imm_ext sampled on that same edge.
- next_pc and taken:
  - taken = branch & ((fun3==3'b000 & zeroflag) | (fun3==3'b001 & ~zeroflag)); taken=0 for any other fun3.
  - next_pc = taken ? instr_pc+imm_ext : instr_pc+32'd4.
  - All additions are 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
- Misaligned target:
  - If next_pc[1:0]!=0 on retirement: go ERR, fetch_err<=1, pc unchanged, instr_valid<=0.
- ERR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - Terminal; only rst leaves this state.
- branch, zeroflag, imm_ext and fun3 are don't-care outside a retirement edge.
- Throughput: at most one instruction per 2 cycles (FETCH with ready, then HOLD).
- Reset mid-request or mid-hold aborts the operation; the following fetch restarts at RESET_PC.

Test Plan:
1. Reset with RESET_PC=0 and imem_ready tied 1, stall=0, branch=0 -> imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle; instr_pc matches each address.
2. Held instr_pc=0x10 with branch=1, fun3=000, zeroflag=1, imm_ext=0xFFFF_FFF8 -> next imem_addr=0x08. Repeat with zeroflag=0 -> 0x14. Repeat with fun3=001, zeroflag=0 -> 0x08.
3. stall=1 for 5 cycles in HOLD -> instr/instr_pc/instr_valid unchanged, imem_req=0, and branch inputs toggling during the stall have no effect. Release stall -> exactly one retirement.
4. imem_ready low for 3 cycles then high -> imem_addr stable for all 4 cycles and instr captured from the ready cycle. imem_ready never high with MAX_WAIT=15 -> fetch_err=1 after 16 request cycles, then imem_req=0 permanently.
5. Retirement with taken branch and imm_ext=0x2 -> fetch_err=1, no further requests. rst pulse -> fetch_err=0 and fetch restarts at RESET_PC.
6. instr_pc=0xFFFF_FFFC with no branch -> next imem_addr=0x0000_0000. Async rst asserted mid-FETCH between edges -> imem_req drops immediately.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from a wait-state memory,
// holds each word for decode and resolves beq/bne when the word retires.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch,
    input  logic [2:0]  fun3,
    input  logic        zeroflag,
    input  logic [31:0] imm_ext,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_err
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;
    logic        taken;
    logic [31:0] next_pc;

    always_comb begin
        taken = 1'b0;
        if (branch) begin
            case (fun3)
                3'b000:  taken = zeroflag;
                3'b001:  taken = ~zeroflag;
                default: taken = 1'b0;
            endcase
        end
    end

    assign next_pc = taken ? (instr_pc + imm_ext) : (instr_pc + 32'd4);

    // Gated by rst so the request drops the instant reset is asserted.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            wait_cnt    <= 8'd0;
            instr       <= NOP;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        wait_cnt    <= 8'd0;
                        state       <= HOLD;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        // A misaligned target is fatal; pc keeps the last good fetch address.
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
                    end
                end
                ERR: begin
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: begin
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                    state       <= ERR;
                end
            endcase
        end
    end

endmodule
